// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler and long-latency scoreboard for the 32x32 register file.
// Arbitrates the single write port between the ALU and LSU and stalls dependent issue.
module regfile_wb_scheduler #(
  parameter int unsigned MAX_LONG     = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_we,
  input  logic        issue_long,
  output logic        issue_stall,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_addr,
  input  logic [31:0] alu_wb_data,
  input  logic        lsu_wb_valid,
  input  logic [4:0]  lsu_wb_addr,
  input  logic [31:0] lsu_wb_data,
  output logic        lsu_wb_ready,
  output logic        rf_write_en,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic [31:0] busy_mask,
  output logic        err_unexpected_wb
);

  localparam int unsigned LCNT_W = $clog2(MAX_LONG + 1);
  localparam int unsigned WCNT_W = $clog2(STARVE_LIMIT + 1);

  logic [LCNT_W-1:0] long_cnt, long_cnt_d;
  logic [WCNT_W-1:0] wait_cnt, wait_cnt_d;
  logic [31:0]       busy_d;
  logic              err_d;
  logic              wr_en_d;
  logic [4:0]        wr_addr_d;
  logic [31:0]       wr_data_d;

  logic hazard, full, starve, grant, tracked, rd_nz, lsu_nz, cnt_inc, cnt_dec;

  // Issue gating and write-port arbitration (ALU has fixed priority)
  assign rd_nz        = (issue_rd != 5'd0);
  assign lsu_nz       = (lsu_wb_addr != 5'd0);
  assign hazard       = busy_mask[issue_rs1] | busy_mask[issue_rs2] |
                        (issue_rd_we & busy_mask[issue_rd]);
  assign full         = issue_long & issue_rd_we & rd_nz &
                        (long_cnt == LCNT_W'(MAX_LONG));
  assign starve       = (wait_cnt == WCNT_W'(STARVE_LIMIT));
  assign issue_stall  = rst | starve | (issue_valid & (hazard | full));
  assign lsu_wb_ready = ~rst & ~alu_wb_valid;
  assign grant        = lsu_wb_valid & lsu_wb_ready;
  assign tracked      = issue_valid & ~issue_stall & issue_long & issue_rd_we & rd_nz;
  assign cnt_inc      = tracked;
  assign cnt_dec      = grant & lsu_nz & (long_cnt != '0);

  // Next-state for scoreboard, counters and write port
  always_comb begin
    busy_d     = busy_mask;
    long_cnt_d = long_cnt;
    wait_cnt_d = wait_cnt;
    err_d      = err_unexpected_wb;
    wr_en_d    = 1'b0;
    wr_addr_d  = rf_write_addr;
    wr_data_d  = rf_write_data;

    if (tracked) busy_d[issue_rd] = 1'b1;
    if (grant) busy_d[lsu_wb_addr] = 1'b0;
    busy_d[0] = 1'b0;

    if (cnt_inc && !cnt_dec) long_cnt_d = long_cnt + LCNT_W'(1);
    else if (cnt_dec && !cnt_inc) long_cnt_d = long_cnt - LCNT_W'(1);

    if (grant || !lsu_wb_valid) wait_cnt_d = '0;
    else if (!starve) wait_cnt_d = wait_cnt + WCNT_W'(1);

    if (grant && lsu_nz && !busy_mask[lsu_wb_addr]) err_d = 1'b1;

    if (alu_wb_valid) begin
      wr_en_d   = (alu_wb_addr != 5'd0);
      wr_addr_d = alu_wb_addr;
      wr_data_d = alu_wb_data;
    end else if (grant) begin
      wr_en_d   = lsu_nz;
      wr_addr_d = lsu_wb_addr;
      wr_data_d = lsu_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_mask         <= '0;
      long_cnt          <= '0;
      wait_cnt          <= '0;
      err_unexpected_wb <= 1'b0;
      rf_write_en       <= 1'b0;
      rf_write_addr     <= '0;
      rf_write_data     <= '0;
    end else begin
      busy_mask         <= busy_d;
      long_cnt          <= long_cnt_d;
      wait_cnt          <= wait_cnt_d;
      err_unexpected_wb <= err_d;
      rf_write_en       <= wr_en_d;
      rf_write_addr     <= wr_addr_d;
      rf_write_data     <= wr_data_d;
    end
  end

endmodule
